// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// Each granted request runs SETUP/ACCESS/DONE, and a bounded wait terminates hung slaves.
module apb_master_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                            pclk,
    input  logic                            preset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            pselx,
    output logic                            penable,
    output logic                            pwrite,
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic [DATA_WIDTH-1:0]           pwdata,
    input  logic [DATA_WIDTH-1:0]           prdata,
    input  logic                            pready,
    input  logic                            pslverr
);
    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  arb_found;
    logic [IdW-1:0]        arb_idx;
    logic [IdW-1:0]        cand;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IdW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        pselx     = 1'b0;
        penable   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Reset gates the acceptance pulse since IDLE is also the reset state.
                if (arb_found && !preset) begin
                    req_ready[arb_idx] = 1'b1;
                    grant_d  = arb_idx;
                    rr_ptr_d = arb_idx;
                    write_d  = sel_write;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                pselx   = 1'b1;
                state_d = StAccess;
            end
            StAccess: begin
                pselx   = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    rdata_d = write_q ? '0 : prdata;
                    err_d   = pslverr;
                    state_d = StDone;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                rsp_valid[grant_q] = 1'b1;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= StIdle;
            rr_ptr_q <= IdW'(NUM_REQ - 1);
            grant_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign grant_id  = grant_q;
    assign pwrite    = write_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter: reset, transfers, fairness,
// timeout, slave error and mid-transfer reset, plus an APB protocol monitor.
module tb_apb_master_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int TO = 16;

    logic             pclk = 1'b0;
    logic             preset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             busy;
    logic [1:0]       grant_id;
    logic             pselx;
    logic             penable;
    logic             pwrite;
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;
    logic [DW-1:0]    prdata;
    logic             pready;
    logic             pslverr;

    int nchk  = 0;
    int npass = 0;

    apb_master_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .TIMEOUT   (TO)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .grant_id (grant_id),
        .pselx    (pselx),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    // APB protocol invariants, sampled mid-cycle.
    logic          prev_sel, prev_pen, prev_wr;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    always @(negedge pclk) begin
        if (preset) begin
            prev_sel = 1'b0;
            prev_pen = 1'b0;
        end else begin
            if (penable) begin
                nchk++;
                if (!pselx) $display("FAIL apb_pen_implies_sel: pselx=%b required 1", pselx);
                else npass++;
            end
            if (penable && !prev_pen) begin
                nchk++;
                if (!(prev_sel && !prev_pen))
                    $display("FAIL apb_pen_rise: prev psel/pen=%b%b required 10", prev_sel, prev_pen);
                else npass++;
            end
            if (pselx && penable && prev_sel) begin
                nchk++;
                if ({paddr, pwrite, pwdata} !== {prev_addr, prev_wr, prev_wdata})
                    $display("FAIL apb_stable: addr/wr/wdata=%h/%b/%h required %h/%b/%h",
                             paddr, pwrite, pwdata, prev_addr, prev_wr, prev_wdata);
                else npass++;
            end
            prev_sel   = pselx;
            prev_pen   = penable;
            prev_addr  = paddr;
            prev_wr    = pwrite;
            prev_wdata = pwdata;
        end
    end

    task automatic test_reset;
        preset = 1'b1; req_valid = 4'hF; req_write = 4'hF; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        tick; tick;
        nchk++;
        if ({pselx, penable, pwrite} !== 3'b000)
            $display("FAIL reset_apb_ctrl: sel/en/wr=%b%b%b required 000", pselx, penable, pwrite);
        else npass++;
        nchk++;
        if ({paddr, pwdata} !== '0) $display("FAIL reset_apb_bus: %h/%h required 0/0", paddr, pwdata);
        else npass++;
        nchk++;
        if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: %b required 0000", req_ready);
        else npass++;
        nchk++;
        if ({rsp_valid, rsp_rdata, rsp_err, busy, grant_id} !== '0)
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b busy=%b gid=%0d required all 0",
                     rsp_valid, rsp_rdata, rsp_err, busy, grant_id);
        else npass++;
        preset = 1'b0;
        #1;
        nchk++;
        if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: %b required 0001", req_ready);
        else npass++;
        tick;
        nchk++;
        if ({grant_id, pselx, penable} !== {2'd0, 2'b10})
            $display("FAIL reset_first_setup: gid=%0d sel/en=%b%b required 0/10", grant_id, pselx, penable);
        else npass++;
        req_valid = '0; pready = 1'b1;
        tick; tick;
        nchk++;
        if (rsp_valid !== 4'b0001) $display("FAIL reset_first_done: %b required 0001", rsp_valid);
        else npass++;
        tick;
    endtask

    task automatic test_single_write;
        req_valid = 4'b0001; req_write = 4'b0001; req_addr[7:0] = 8'h10; req_wdata[15:0] = 16'hA5A5;
        pready = 1'b1;
        #1;
        nchk++;
        if (req_ready !== 4'b0001) $display("FAIL wr_req_ready: %b required 0001", req_ready);
        else npass++;
        tick;
        nchk++;
        if ({pselx, penable, paddr, pwrite, pwdata, busy} !== {2'b10, 8'h10, 1'b1, 16'hA5A5, 1'b1})
            $display("FAIL wr_setup: sel/en=%b%b addr=%h wr=%b wdata=%h busy=%b required 10/10/1/a5a5/1",
                     pselx, penable, paddr, pwrite, pwdata, busy);
        else npass++;
        req_valid = '0; req_addr[7:0] = 8'h77;
        tick;
        nchk++;
        if ({pselx, penable, paddr} !== {2'b11, 8'h10})
            $display("FAIL wr_access: sel/en=%b%b addr=%h required 11/10", pselx, penable, paddr);
        else npass++;
        tick;
        nchk++;
        if ({rsp_valid, rsp_err, rsp_rdata, pselx} !== {4'b0001, 1'b0, 16'h0, 1'b0})
            $display("FAIL wr_done: valid=%b err=%b rdata=%h sel=%b required 0001/0/0000/0",
                     rsp_valid, rsp_err, rsp_rdata, pselx);
        else npass++;
        tick;
        nchk++;
        if ({rsp_valid, busy, paddr} !== {4'b0000, 1'b0, 8'h10})
            $display("FAIL wr_idle_hold: valid=%b busy=%b addr=%h required 0000/0/10", rsp_valid, busy, paddr);
        else npass++;
    endtask

    task automatic test_read_wait;
        req_valid = 4'b0100; req_write = 4'b0000; req_addr[23:16] = 8'h20; pready = 1'b0;
        #1;
        nchk++;
        if (req_ready !== 4'b0100) $display("FAIL rd_req_ready: %b required 0100", req_ready);
        else npass++;
        tick;
        nchk++;
        if ({paddr, pwrite, grant_id} !== {8'h20, 1'b0, 2'd2})
            $display("FAIL rd_setup: addr=%h wr=%b gid=%0d required 20/0/2", paddr, pwrite, grant_id);
        else npass++;
        req_valid = '0; req_addr[23:16] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (i == 3) begin
                pready = 1'b1; prdata = 16'h1234;
            end
            nchk++;
            if ({penable, paddr} !== {1'b1, 8'h20})
                $display("FAIL rd_access_%0d: en=%b addr=%h required 1/20", i, penable, paddr);
            else npass++;
        end
        tick;
        nchk++;
        if ({rsp_valid, rsp_rdata, rsp_err, penable} !== {4'b0100, 16'h1234, 1'b0, 1'b0})
            $display("FAIL rd_done: valid=%b rdata=%h err=%b en=%b required 0100/1234/0/0",
                     rsp_valid, rsp_rdata, rsp_err, penable);
        else npass++;
        pready = 1'b0;
        tick;
        nchk++;
        if (rsp_rdata !== 16'h1234) $display("FAIL rd_hold: rdata=%h required 1234", rsp_rdata);
        else npass++;
    endtask

    task automatic test_fairness;
        logic [3:0] exp_oh;
        preset = 1'b1;
        #1;
        preset = 1'b0;
        req_valid = 4'hF; req_write = 4'h0; pready = 1'b1; prdata = 16'hBEEF; pslverr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_oh = 4'(1) << (k % 4);
            #1;
            nchk++;
            if (req_ready !== exp_oh) $display("FAIL rr_ready_%0d: %b required %b", k, req_ready, exp_oh);
            else npass++;
            tick;
            nchk++;
            if (grant_id !== 2'(k % 4)) $display("FAIL rr_grant_%0d: %0d required %0d", k, grant_id, k % 4);
            else npass++;
            tick; tick;
            nchk++;
            if ({rsp_valid, rsp_rdata, rsp_err} !== {exp_oh, 16'hBEEF, 1'b0})
                $display("FAIL rr_done_%0d: valid=%b rdata=%h err=%b required %b/beef/0",
                         k, rsp_valid, rsp_rdata, rsp_err, exp_oh);
            else npass++;
            tick;
            if (k == 7) req_valid = '0;
        end
    endtask

    task automatic test_timeout;
        int acc;
        req_valid = 4'b0010; req_write = 4'b0000; pready = 1'b0;
        #1;
        nchk++;
        if (req_ready !== 4'b0010) $display("FAIL to_req_ready: %b required 0010", req_ready);
        else npass++;
        tick;
        req_valid = '0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (pselx && penable) acc++;
            else break;
        end
        nchk++;
        if (acc !== TO) $display("FAIL to_access_cycles: %0d required %0d", acc, TO);
        else npass++;
        nchk++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0010, 1'b1, 16'h0})
            $display("FAIL to_done: valid=%b err=%b rdata=%h required 0010/1/0000",
                     rsp_valid, rsp_err, rsp_rdata);
        else npass++;
        tick;
        req_valid = 4'b1000; pready = 1'b1; pslverr = 1'b1; prdata = 16'h5555;
        #1;
        nchk++;
        if (req_ready !== 4'b1000) $display("FAIL err_req_ready: %b required 1000", req_ready);
        else npass++;
        tick;
        req_valid = '0;
        tick; tick;
        nchk++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b1000, 1'b1, 16'h5555})
            $display("FAIL err_done: valid=%b err=%b rdata=%h required 1000/1/5555",
                     rsp_valid, rsp_err, rsp_rdata);
        else npass++;
        pslverr = 1'b0; pready = 1'b0;
        tick;
        nchk++;
        if ({rsp_valid, rsp_err} !== {4'b0000, 1'b1})
            $display("FAIL err_hold: valid=%b err=%b required 0000/1", rsp_valid, rsp_err);
        else npass++;
    endtask

    task automatic test_reset_mid;
        req_valid = 4'b0100; pready = 1'b0;
        #1;
        nchk++;
        if (req_ready !== 4'b0100) $display("FAIL rm_req_ready: %b required 0100", req_ready);
        else npass++;
        tick;
        req_valid = '0;
        tick; tick;
        nchk++;
        if (penable !== 1'b1) $display("FAIL rm_in_access: en=%b required 1", penable);
        else npass++;
        preset = 1'b1;
        #1;
        nchk++;
        if ({pselx, penable, busy} !== 3'b000)
            $display("FAIL rm_async_drop: sel/en/busy=%b%b%b required 000", pselx, penable, busy);
        else npass++;
        req_valid = 4'b0101;
        #1;
        nchk++;
        if (req_ready !== 4'b0000) $display("FAIL rm_ready_in_reset: %b required 0000", req_ready);
        else npass++;
        for (int i = 0; i < 2; i++) begin
            tick;
            nchk++;
            if (rsp_valid !== 4'b0000) $display("FAIL rm_no_rsp_%0d: %b required 0000", i, rsp_valid);
            else npass++;
        end
        preset = 1'b0;
        #1;
        nchk++;
        if (req_ready !== 4'b0001) $display("FAIL rm_regrant: %b required 0001", req_ready);
        else npass++;
        tick;
        nchk++;
        if (grant_id !== 2'd0) $display("FAIL rm_grant_id: %0d required 0", grant_id);
        else npass++;
        req_valid = '0; pready = 1'b1;
        tick; tick;
        nchk++;
        if (rsp_valid !== 4'b0001) $display("FAIL rm_done: %b required 0001", rsp_valid);
        else npass++;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_write;
        test_read_wait;
        test_fairness;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
